// File: rtl/run_control.sv
// Front-panel run control: debounces the run/step/speed buttons and drives the
// clock divider's halt/setFreq so a single step releases exactly one slow-clock edge.
module run_control #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btnRun,
    input  logic             btnStep,
    input  logic             btnSpeed,
    input  logic             reg1Hz,
    input  logic             cpuHalt,
    output logic             halt,
    output logic             setFreq,
    output logic [1:0]       runState,
    output logic [CNT_W-1:0] edgeCount
);

    // state      | meaning
    // STOPPED    | slow clock frozen, waiting for run or step
    // RUNNING    | slow clock free-running
    // STEP       | released, waiting for one reg1Hz rising edge
    // STEP_DRAIN | halt requested, waiting for reg1Hz to fall
    typedef enum logic [1:0] {
        STOPPED    = 2'b00,
        RUNNING    = 2'b01,
        STEP       = 2'b10,
        STEP_DRAIN = 2'b11
    } state_t;

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]      btn_raw;
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      accepted;
    logic [DB_W-1:0] db_cnt [3];
    logic [2:0]      press;
    logic            r1d;
    logic            rise;
    state_t          state;

    assign btn_raw = {btnSpeed, btnStep, btnRun};

    // A press fires in the cycle before the accepted level flips, so the FSM
    // acts on the same edge that accepts the new level.
    always_comb begin
        press = '0;
        for (int i = 0; i < 3; i++) begin
            press[i] = sync2[i] & ~accepted[i] & (db_cnt[i] == DB_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            accepted <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != accepted[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        accepted[i] <= sync2[i];
                        db_cnt[i]   <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign rise = reg1Hz & ~r1d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r1d       <= 1'b0;
            edgeCount <= '0;
        end else begin
            r1d <= reg1Hz;
            if (rise) begin
                edgeCount <= edgeCount + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            setFreq <= 1'b0;
        end else if (press[2]) begin
            setFreq <= ~setFreq;
        end
    end

    // halt follows the state one cycle later, except cpuHalt raises it at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= STOPPED;
            halt  <= 1'b1;
        end else begin
            halt <= ~((state == RUNNING) || (state == STEP)) | cpuHalt;
            case (state)
                STOPPED: begin
                    if (!cpuHalt) begin
                        if (press[0]) begin
                            state <= RUNNING;
                        end else if (press[1]) begin
                            state <= STEP;
                        end
                    end
                end
                RUNNING: begin
                    if (press[0] || cpuHalt) begin
                        state <= STOPPED;
                    end
                end
                STEP: begin
                    if (cpuHalt) begin
                        state <= STOPPED;
                    end else if (rise) begin
                        state <= STEP_DRAIN;
                    end
                end
                STEP_DRAIN: begin
                    if (!reg1Hz) begin
                        state <= STOPPED;
                    end
                end
                default: state <= STOPPED;
            endcase
        end
    end

    assign runState = state;

endmodule

// File: doc/run_control.md
Name: run_control

Overview:
- Front-panel run-control stage directly upstream of the processor clock divider.
- Debounces board push-buttons and drives the divider's `halt` and `setFreq` inputs.
- Implements run/stop, single-step and fast/slow toggling.
- Watches the divider's slow-clock output (`reg1Hz`) so a single step releases exactly one slow-clock rising edge to the processor.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles required before a button level is accepted (1 ms at 50 MHz).
- CNT_W, 32, width of the slow-clock edge counter.

Ports:
- clk  input  1  system clock, same clock as the divider
- reset  input  1  synchronous, active-high; all state initialised on the rising edge of clk while high
- btnRun  input  1  raw run/stop button, active-high, asynchronous to clk
- btnStep  input  1  raw single-step button, active-high, asynchronous
- btnSpeed  input  1  raw fast/slow toggle button, active-high, asynchronous
- reg1Hz  input  1  slow clock fed back from the divider
- cpuHalt  input  1  processor has executed a halt instruction, level
- halt  output  1  to divider; 1 = freeze slow clock once it is low
- setFreq  output  1  to divider; 1 = fast, 0 = slow
- runState  output  2  00 STOPPED, 01 RUNNING, 10 STEP, 11 STEP_DRAIN
- edgeCount  output  CNT_W  number of reg1Hz rising edges since reset

Behaviour:
- Clocking and reset:
  - All logic is on posedge clk.
  - Reset values: halt=1, setFreq=0, runState=STOPPED, edgeCount=0.
  - All debouncers clear to accepted level 0 with their counter at 0.
  - Reset mid-step or mid-run returns to these values in the next cycle. There is no pending-event memory.
- Input conditioning, per button:
  - Each raw button passes through a 2-flop synchroniser.
  - The debounce counter increments while the synchronised level differs from the accepted level. It clears to 0 whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the accepted level flips and the counter clears.
  - A press event is a 1-cycle pulse on an accepted 0->1 transition. Releases produce no event.
  - Latency from a clean raw edge to the press pulse is 2 + DEBOUNCE_CYCLES cycles.
- Slow-clock edge detection:
  - reg1Hz is registered once (`r1d`).
  - rise = reg1Hz & ~r1d.
  - edgeCount increments on every rise, regardless of state, and wraps modulo 2^CNT_W.
- Speed:
  - Each speed press toggles setFreq, in any state.
  - setFreq changes the cycle after the press pulse.
- FSM, where halt is a registered decode (halt=0 only in RUNNING and STEP):
  - STOPPED:
    - run press with cpuHalt=0 -> RUNNING.
    - Otherwise, step press with cpuHalt=0 -> STEP.
    - If run and step press in the same cycle, run wins.
  - RUNNING:
    - run press -> STOPPED.
    - cpuHalt=1 -> STOPPED.
    - Step presses are ignored.
  - STEP:
    - rise -> STEP_DRAIN.
    - cpuHalt=1 -> STOPPED.
    - Run and step presses are ignored.
  - STEP_DRAIN (halt=1; the divider keeps counting until reg1Hz is low):
    - reg1Hz==0 -> STOPPED.
    - Presses are ignored.
  - While cpuHalt=1, run and step presses in STOPPED are ignored. Only reset or cpuHalt deasserting re-enables them.
- Guaranteed property: exactly one reg1Hz rising edge occurs between entering STEP and returning to STOPPED.
- Boundary rules:
  - A rise coincident with the STOPPED->STEP transition cycle is not counted as the step edge. Only rises observed while in STEP count.
  - A button held indefinitely yields one press.
  - Bounce shorter than DEBOUNCE_CYCLES yields no event.

Test Plan (bench uses DEBOUNCE_CYCLES=4, paired with the real divider):
- Glitch rejection:
  - Stimulus: btnRun pulsed high 3 cycles, low 5, then high 10 cycles.
  - Required: exactly one run press; runState 00->01 on cycle 2+4 after the final rise; halt drops to 0 one cycle later.
- Single step:
  - Stimulus: from STOPPED with setFreq=1, press btnStep.
  - Required: runState visits 10 then 11 then 00; edgeCount increments by exactly 1; halt=1 and reg1Hz=0 at the end.
  - Repeat 5 times; required edgeCount=5.
- Run/stop:
  - Stimulus: press run, wait 40 cycles at fast speed, press run.
  - Required: edgeCount>0 and halt returns to 1.
  - Required: once reg1Hz is low, edgeCount is frozen for 100 further cycles.
- cpuHalt:
  - Stimulus: assert cpuHalt while RUNNING.
  - Required: STOPPED and halt=1 on the next cycle.
  - Stimulus: press run and press step while cpuHalt is still 1.
  - Required: runState stays 00.
- Speed toggle and simultaneous press:
  - Stimulus: three btnSpeed presses.
  - Required: setFreq goes 1, 0, 1.
  - Stimulus: run and step pressed the same cycle from STOPPED.
  - Required: runState goes to 01.
- Reset mid-step:
  - Stimulus: assert reset during STEP.
  - Required: next cycle halt=1, setFreq=0, runState=00, edgeCount=0.
